// File: rtl/any1_bmm_inv_pkg.sv
// Shared types and constants for the BMM matrix inverter: state enum, latency and the identity value.
// Matrix element [i][j] lives at bit (N-i)*(N+1)+(N-j), the same mapping BMM MXOR uses.
package any1_bmm_inv_pkg;

    localparam int DBW = 64;
    localparam int N   = 7;
    localparam int BMM_INV_LAT = 2*(N+1)+1;

    typedef logic [DBW-1:0] value_t;

    typedef enum logic [1:0] {IDLE, PIVOT, ELIM, DONE} bmm_inv_state_t;

    function automatic value_t bmm_identity();
        value_t r;
        r = '0;
        for (int i = 0; i <= N; i++) begin
            r[(N-i)*(N+1)+(N-i)] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/any1_bmm_inv_if.sv
// Request/result bundle of the BMM inverter; master is the ALU side, slave is the inverter.
// ANY1_BMMINV_TRANSPOSE_EN adds the xpose_i request qualifier.
interface any1_bmm_inv_if;
    import any1_bmm_inv_pkg::*;

    logic   req_i;
    value_t a_i;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
    logic   xpose_i;
`endif
    logic   ready_o;
    logic   done_o;
    logic   singular_o;
    value_t o;

`ifdef ANY1_BMMINV_TRANSPOSE_EN
    modport master (output req_i, a_i, xpose_i, input ready_o, done_o, singular_o, o);
    modport slave  (input req_i, a_i, xpose_i, output ready_o, done_o, singular_o, o);
`else
    modport master (output req_i, a_i, input ready_o, done_o, singular_o, o);
    modport slave  (input req_i, a_i, output ready_o, done_o, singular_o, o);
`endif

endinterface

// File: rtl/any1_bmm_inv_pivot.sv
// Combinational pivot finder: lowest row index r >= c whose bit in the given column is set.
module any1_bmm_pivot #(
    parameter int N  = 7,
    parameter int CW = (N > 0) ? $clog2(N+1) : 1
) (
    input  logic [0:N]    col,
    input  logic [CW-1:0] c,
    output logic          found,
    output logic [CW-1:0] p
);

    // Scan downward so the lowest qualifying row is the last one written.
    always_comb begin
        found = 1'b0;
        p     = '0;
        for (int r = N; r >= 0; r--) begin
            if (col[r] && (CW'(r) >= c)) begin
                found = 1'b1;
                p     = CW'(r);
            end
        end
    end

endmodule

// File: rtl/any1_bmm_inv.sv
// Iterative GF(2) Gauss-Jordan inverter for (N+1)x(N+1) bit matrices: one pivot/swap and one
// eliminate cycle per column. Optional ANY1_BMMINV_TRANSPOSE_EN returns the transposed inverse.
module any1_bmm_inv
    import any1_bmm_inv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    any1_bmm_inv_if.slave bus
);

    localparam int CW = (N > 0) ? $clog2(N+1) : 1;
    localparam int SQ = (N+1)*(N+1);
    localparam value_t IDENT_V = bmm_identity();
    localparam logic [0:N][0:N] IDENT = IDENT_V[SQ-1:0];

    bmm_inv_state_t  state_reg, state_next;
    logic [0:N][0:N] m_reg, m_next;
    logic [0:N][0:N] i_reg, i_next;
    logic [CW-1:0]   c_reg, c_next;
    logic            sing_reg, sing_next;
    value_t          o_reg, o_next;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
    logic            xpose_reg, xpose_next;
`endif

    logic [0:N]      col;
    logic            found;
    logic [CW-1:0]   p;
    logic [0:N][0:N] e_m, e_i;

    for (genvar gi = 0; gi <= N; gi++) begin : g_col
        assign col[gi] = m_reg[gi][c_reg];
    end

    any1_bmm_pivot #(.N(N), .CW(CW)) u_pivot (
        .col   (col),
        .c     (c_reg),
        .found (found),
        .p     (p)
    );

    // Row c already holds the pivot; clear column c from every other row at once.
    always_comb begin
        e_m = m_reg;
        e_i = i_reg;
        for (int r = 0; r <= N; r++) begin
            if ((CW'(r) != c_reg) && m_reg[r][c_reg]) begin
                e_m[r] = m_reg[r] ^ m_reg[c_reg];
                e_i[r] = i_reg[r] ^ i_reg[c_reg];
            end
        end
    end

`ifdef ANY1_BMMINV_TRANSPOSE_EN
    logic [0:N][0:N] e_t;
    for (genvar gi = 0; gi <= N; gi++) begin : g_tr_row
        for (genvar gj = 0; gj <= N; gj++) begin : g_tr_col
            assign e_t[gi][gj] = e_i[gj][gi];
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        i_next     = i_reg;
        c_next     = c_reg;
        sing_next  = sing_reg;
        o_next     = o_reg;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
        xpose_next = xpose_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.req_i) begin
                    m_next     = bus.a_i[SQ-1:0];
                    i_next     = IDENT;
                    c_next     = '0;
                    sing_next  = 1'b0;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
                    xpose_next = bus.xpose_i;
`endif
                    state_next = PIVOT;
                end
            end
            PIVOT: begin
                if (!found) begin
                    sing_next  = 1'b1;
                    o_next     = '0;
                    state_next = DONE;
                end else begin
                    // When p == c both writes carry the same row, so the swap is a no-op.
                    m_next[c_reg] = m_reg[p];
                    m_next[p]     = m_reg[c_reg];
                    i_next[c_reg] = i_reg[p];
                    i_next[p]     = i_reg[c_reg];
                    state_next    = ELIM;
                end
            end
            ELIM: begin
                m_next = e_m;
                i_next = e_i;
                if (c_reg == CW'(N)) begin
`ifdef ANY1_BMMINV_TRANSPOSE_EN
                    o_next = xpose_reg ? value_t'(e_t) : value_t'(e_i);
`else
                    o_next = value_t'(e_i);
`endif
                    state_next = DONE;
                end else begin
                    c_next     = c_reg + 1'b1;
                    state_next = PIVOT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            i_reg     <= '0;
            c_reg     <= '0;
            sing_reg  <= 1'b0;
            o_reg     <= '0;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
            xpose_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            i_reg     <= i_next;
            c_reg     <= c_next;
            sing_reg  <= sing_next;
            o_reg     <= o_next;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
            xpose_reg <= xpose_next;
`endif
        end
    end

    assign bus.ready_o    = (state_reg == IDLE);
    assign bus.done_o     = (state_reg == DONE);
    assign bus.singular_o = sing_reg;
    assign bus.o          = o_reg;

endmodule

// File: tb/tb_any1_bmm_inv.sv
// Bench for any1_bmm_inv: directed and random 8x8 matrices checked every cycle against a
// brute-force kernel/inverse model (all 256 column combinations) and hand-computed literals.
module tb_any1_bmm_inv;

    localparam logic [63:0] IDENT = 64'h8040201008040201;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    any1_bmm_inv_if bus();

    any1_bmm_inv dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [63:0] lit_o;
    bit          lit_valid;

    // Every x in 0..255 selects a set of columns; A*x is their XOR. A nonzero x with A*x == 0
    // means singular, and the smallest top column among such x is where the pivot search fails.
    function automatic void model(input logic [63:0] a, output logic [63:0] inv,
                                  output bit sing, output int cf);
        logic [7:0] col [8];
        logic [7:0] tbl [256];
        logic [7:0] x, y;
        int h;
        inv  = '0;
        sing = 1'b0;
        cf   = 8;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++)
                col[j][i] = a[(7-i)*8+(7-j)];
        for (int xv = 0; xv < 256; xv++) begin
            x = 8'(xv);
            y = 8'h00;
            for (int j = 0; j < 8; j++)
                if (x[j]) y = y ^ col[j];
            tbl[y] = x;
            if (y == 8'h00 && xv != 0) begin
                sing = 1'b1;
                h = 0;
                for (int k = 0; k < 8; k++)
                    if (x[k]) h = k;
                if (h < cf) cf = h;
            end
        end
        if (!sing) begin
            for (int j = 0; j < 8; j++) begin
                x = tbl[8'(1 << j)];
                for (int i = 0; i < 8; i++)
                    inv[(7-i)*8+(7-j)] = x[i];
            end
        end
    endfunction

    function automatic logic [63:0] mxor(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic s;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 1'b0;
                for (int k = 0; k < 8; k++)
                    s = s ^ (a[(7-i)*8+(7-k)] & b[(7-k)*8+(7-j)]);
                r[(7-i)*8+(7-j)] = s;
            end
        return r;
    endfunction

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: busy counts cycles left until the expected done pulse (1 = done cycle).
    int          busy = 0;
    bit          cur_sing = 1'b0;
    logic [63:0] cur_o = '0;
    logic [63:0] pa, po, plit;
    bit          ps, plit_v;
    int          cf;
    int          op_n = 0;

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                busy     = 0;
                cur_sing = 1'b0;
                cur_o    = '0;
                chk1("rst_ready", bus.ready_o, 1'b1);
                chk1("rst_done", bus.done_o, 1'b0);
                chk1("rst_sing", bus.singular_o, 1'b0);
                chk64("rst_o", bus.o, 64'h0);
            end else begin
                chk1("ready", bus.ready_o, busy == 0);
                chk1("done", bus.done_o, busy == 1);
                if (busy == 1) begin
                    chk1("singular", bus.singular_o, ps);
                    chk64("o", bus.o, po);
                    if (plit_v) chk64("o_literal", bus.o, plit);
                    if (!ps) chk64("mxor_identity", mxor(pa, bus.o), IDENT);
                    $display("op %0d: a=%h o=%h singular=%0b", op_n, pa, bus.o, bus.singular_o);
                    op_n++;
                    cur_sing = ps;
                    cur_o    = po;
                end else if (busy == 0) begin
                    chk1("hold_sing", bus.singular_o, cur_sing);
                    chk64("hold_o", bus.o, cur_o);
                end else begin
                    chk1("busy_sing", bus.singular_o, 1'b0);
                end
                if (busy > 0) begin
                    busy--;
                end else if (bus.req_i) begin
                    pa = bus.a_i;
                    model(pa, po, ps, cf);
                    busy     = ps ? (2*cf + 2) : 17;
                    plit     = lit_o;
                    plit_v   = lit_valid;
                    cur_sing = 1'b0;
                end
            end
        end
    end

    task automatic op(input logic [63:0] a, input bit lv, input logic [63:0] lo);
        @(posedge clk);
        #1;
        bus.a_i   = a;
        lit_valid = lv;
        lit_o     = lo;
        bus.req_i = 1'b1;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        repeat (17) @(posedge clk);
    endtask

    initial begin
        logic [63:0] ra;
        bus.req_i = 1'b0;
        bus.a_i   = '0;
`ifdef ANY1_BMMINV_TRANSPOSE_EN
        bus.xpose_i = 1'b0;
`endif
        lit_valid = 1'b0;
        lit_o     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        op(IDENT, 1'b1, IDENT);
        op(64'h0102040810204080, 1'b1, 64'h0102040810204080);
        op(64'hFF7F3F1F0F070301, 1'b1, 64'hC06030180C060301);
        op(64'h0, 1'b1, 64'h0);
        op(64'h8040201008040202, 1'b1, 64'h0);

        // Hold req high through a whole operation, then reset during ELIM of the re-accepted one.
        @(posedge clk);
        #1;
        bus.a_i   = 64'hFF7F3F1F0F070301;
        lit_valid = 1'b1;
        lit_o     = 64'hC06030180C060301;
        bus.req_i = 1'b1;
        repeat (22) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        bus.req_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        lit_valid = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 1000; k++) begin
            ra = {$urandom, $urandom};
            if (k % 4 == 1) ra[7:0] = ra[(7-(k%7))*8 +: 8];
            op(ra, 1'b0, 64'h0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
